// File: rtl/rf_pkg.sv
// Shared widths, constants and payload type for the register-file writeback arbiter.
package rf_pkg;

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;
   localparam logic              PORT_ALU = 1'b0;
   localparam logic              PORT_LD  = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, query muxes and
// detection of writes that land on an unreserved register.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              clr_valid,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] q_rs_addr,
   input  logic [ADDR_W-1:0] q_rt_addr,
   input  logic [ADDR_W-1:0] q_rd_addr,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic              rd_busy,
   output logic              err_unrsv
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;
   logic                set_err_c;

   // Clear first so a same-edge reserve of the same register wins.
   always_comb begin
      busy_next = busy;
      if (clr_valid) busy_next[clr_addr] = 1'b0;
      if (rsv_valid) busy_next[rsv_addr] = 1'b1;
      busy_next[REG_ZERO] = 1'b0;
   end

   assign set_err_c = clr_valid && (clr_addr != REG_ZERO) && !busy[clr_addr]
                      && !(rsv_valid && (rsv_addr == clr_addr));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= '0;
         err_unrsv <= 1'b0;
      end else begin
         busy <= busy_next;
         if (set_err_c) err_unrsv <= 1'b1;
      end
   end

   assign rs_busy = busy[q_rs_addr];
   assign rt_busy = busy[q_rt_addr];
   assign rd_busy = busy[q_rd_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load writeback paths, with a registered write port and hazard scoreboard.
module rf_wb_arbiter
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wb0_valid,
   input  logic [ADDR_W-1:0] wb0_addr,
   input  logic [DATA_W-1:0] wb0_data,
   output logic              wb0_ready,
   input  logic              wb1_valid,
   input  logic [ADDR_W-1:0] wb1_addr,
   input  logic [DATA_W-1:0] wb1_data,
   output logic              wb1_ready,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic [ADDR_W-1:0] q_rs_addr,
   input  logic [ADDR_W-1:0] q_rt_addr,
   input  logic [ADDR_W-1:0] q_rd_addr,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic              rd_busy,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              err_unrsv
);

   logic    last_grant;
   logic    grant0_c;
   logic    grant1_c;
   logic    accept_c;
   wb_req_t sel_c;

   // Under contention the port that did not win last time is granted.
   always_comb begin
      grant0_c = wb0_valid && (!wb1_valid || (last_grant == PORT_LD));
      grant1_c = wb1_valid && (!wb0_valid || (last_grant == PORT_ALU));
      accept_c = grant0_c || grant1_c;
      if (grant1_c) begin
         sel_c.addr = wb1_addr;
         sel_c.data = wb1_data;
      end else begin
         sel_c.addr = wb0_addr;
         sel_c.data = wb0_data;
      end
   end

   assign wb0_ready = grant0_c;
   assign wb1_ready = grant1_c;

   // Writes to register 0 are consumed without raising the write enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         last_grant <= PORT_LD;
      end else begin
         rf_we <= accept_c && (sel_c.addr != REG_ZERO);
         if (accept_c) begin
            rf_waddr   <= sel_c.addr;
            rf_wdata   <= sel_c.data;
            last_grant <= grant1_c ? PORT_LD : PORT_ALU;
         end
      end
   end

   rf_scoreboard u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .clr_valid (accept_c),
      .clr_addr  (sel_c.addr),
      .q_rs_addr (q_rs_addr),
      .q_rt_addr (q_rt_addr),
      .q_rd_addr (q_rd_addr),
      .rs_busy   (rs_busy),
      .rt_busy   (rt_busy),
      .rd_busy   (rd_busy),
      .err_unrsv (err_unrsv)
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of arbitration, write port and scoreboard.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wb0_valid = 1'b0, wb1_valid = 1'b0, rsv_valid = 1'b0;
   logic [4:0]  wb0_addr = '0, wb1_addr = '0, rsv_addr = '0;
   logic [31:0] wb0_data = '0, wb1_data = '0;
   logic [4:0]  q_rs_addr = '0, q_rt_addr = '0, q_rd_addr = '0;
   logic        wb0_ready, wb1_ready, rs_busy, rt_busy, rd_busy;
   logic        rf_we, err_unrsv;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   bit          m_busy [32];
   int          last_g;
   logic        m_we, m_err;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic [31:0] mem [32];

   int          g;
   logic        p0v, p1v;
   logic [4:0]  p0a, p1a;
   logic [31:0] p0d, p1d;

   rf_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .q_rs_addr(q_rs_addr), .q_rt_addr(q_rt_addr), .q_rd_addr(q_rd_addr),
      .rs_busy(rs_busy), .rt_busy(rt_busy), .rd_busy(rd_busy),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err_unrsv(err_unrsv)
   );

   always #5 clk = ~clk;

   // Register file: commits on the falling edge
   always @(negedge clk) if (rf_we === 1'b1) mem[rf_waddr] <= rf_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      last_g  = 1;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_err   = 1'b0;
   endtask

   task automatic idle_inputs();
      wb0_valid = 1'b0; wb1_valid = 1'b0; rsv_valid = 1'b0;
   endtask

   // Assert reset (async), check outputs clear immediately, hold two edges, release mid-cycle.
   task automatic apply_reset();
      rst = 1'b1;
      idle_inputs();
      q_rs_addr = 5'd9; q_rt_addr = 5'd10; q_rd_addr = 5'd12;
      #1;
      model_reset();
      p0v = 1'b0; p1v = 1'b0;
      chk("rst_we", rf_we, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_err", err_unrsv, 0);
      chk("rst_busy", {rs_busy, rt_busy, rd_busy}, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One clock: check handshake and busy outputs before the edge, then the registered outputs after.
   task automatic cycle(output int gr);
      logic [4:0]  a;
      logic [31:0] d;
      #1;
      gr = -1;
      if (wb0_valid && wb1_valid) gr = 1 - last_g;
      else if (wb0_valid)         gr = 0;
      else if (wb1_valid)         gr = 1;
      chk("ready0", wb0_ready, gr == 0);
      chk("ready1", wb1_ready, gr == 1);
      chk("rs_busy", rs_busy, m_busy[q_rs_addr]);
      chk("rt_busy", rt_busy, m_busy[q_rt_addr]);
      chk("rd_busy", rd_busy, m_busy[q_rd_addr]);
      @(posedge clk);
      if (gr >= 0) begin
         a = (gr == 1) ? wb1_addr : wb0_addr;
         d = (gr == 1) ? wb1_data : wb0_data;
         last_g  = gr;
         m_waddr = a;
         m_wdata = d;
         m_we    = (a != 0);
         if (a != 0 && !m_busy[a] && !(rsv_valid && rsv_addr == a)) m_err = 1'b1;
         if (a != 0) m_busy[a] = 1'b0;
      end else begin
         m_we = 1'b0;
      end
      if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      #1;
      chk("rf_we", rf_we, m_we);
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("err_unrsv", err_unrsv, m_err);
   endtask

   initial begin
      model_reset();
      #2;
      apply_reset();

      // Contention right after reset: both ports held, grants alternate starting with port 0
      wb0_valid = 1'b1; wb0_addr = 5'd10; wb0_data = 32'hA;
      wb1_valid = 1'b1; wb1_addr = 5'd12; wb1_data = 32'hB;
      q_rs_addr = 5'd10; q_rt_addr = 5'd12;
      rsv_valid = 1'b1; rsv_addr = 5'd10;
      cycle(g); chk("cont_g0", g, 0);
      rsv_addr = 5'd12;
      cycle(g); chk("cont_g1", g, 1);
      rsv_valid = 1'b0;
      chk("cont_mem10", mem[10], 32'hA);
      cycle(g); chk("cont_g2", g, 0);
      chk("cont_mem12", mem[12], 32'hB);
      cycle(g); chk("cont_g3", g, 1);
      idle_inputs();
      cycle(g);

      // Single port: reserve r9, then ALU writes it
      q_rs_addr = 5'd9;
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      cycle(g);
      rsv_valid = 1'b0;
      wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h0000_1234;
      cycle(g); chk("single_g", g, 0);
      chk("single_we", rf_we, 1);
      chk("single_busy_clr", rs_busy, 0);
      idle_inputs();
      cycle(g);
      chk("single_mem", mem[9], 32'h0000_1234);

      // Register 0: consumed silently
      wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'hFFFF_FFFF;
      q_rs_addr = 5'd0;
      cycle(g); chk("zero_g", g, 1);
      chk("zero_we", rf_we, 0);
      chk("zero_err", err_unrsv, 0);
      idle_inputs();

      // Reserve and clear of the same register on one edge: stays busy
      q_rd_addr = 5'd9;
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      cycle(g);
      wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h99;
      cycle(g);
      idle_inputs();
      chk("collide_busy", rd_busy, 1);
      cycle(g);
      wb0_valid = 1'b1;
      cycle(g);
      idle_inputs();
      chk("collide_clr", rd_busy, 0);
      chk("collide_err", err_unrsv, 0);

      // Unreserved write raises the sticky error
      wb0_valid = 1'b1; wb0_addr = 5'd11; wb0_data = 32'h11;
      cycle(g);
      idle_inputs();
      chk("unrsv_err", err_unrsv, 1);
      cycle(g);
      chk("unrsv_sticky", err_unrsv, 1);

      // Random traffic; requesters hold their request until accepted
      p0v = 1'b0; p1v = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!p0v && ($urandom_range(0, 2) != 0)) begin
            p0v = 1'b1; p0a = 5'($urandom_range(0, 31)); p0d = $urandom;
         end
         if (!p1v && ($urandom_range(0, 2) != 0)) begin
            p1v = 1'b1; p1a = 5'($urandom_range(0, 31)); p1d = $urandom;
         end
         wb0_valid = p0v; wb0_addr = p0a; wb0_data = p0d;
         wb1_valid = p1v; wb1_addr = p1a; wb1_data = p1d;
         rsv_valid = ($urandom_range(0, 1) == 1);
         rsv_addr  = 5'($urandom_range(0, 31));
         q_rs_addr = 5'($urandom_range(0, 31));
         q_rt_addr = 5'($urandom_range(0, 31));
         q_rd_addr = 5'($urandom_range(0, 31));
         cycle(g);
         if (g == 0) p0v = 1'b0;
         if (g == 1) p1v = 1'b0;
      end
      idle_inputs();
      cycle(g);

      // Reset mid-stream while a write is on the port
      wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'h5555;
      cycle(g);
      chk("mid_we_before", rf_we, 1);
      apply_reset();

      // First contention after reset goes to port 0
      wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'h1;
      wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h2;
      cycle(g); chk("post_rst_g", g, 0);
      idle_inputs();
      cycle(g);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port 0 (ALU writeback) and port 1 (load/multi-cycle writeback).
- Keeps a 32-entry pending-write scoreboard so the issue stage can detect RAW and WAW hazards against in-flight writes.
- Drives the register file write port (write enable, write address, write data) from registered outputs; the register file commits on the falling clock edge.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width; 2**ADDR_W registers.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb0_valid  in  1  port 0 (ALU) write request.
- wb0_addr  in  ADDR_W  port 0 destination register.
- wb0_data  in  DATA_W  port 0 write data.
- wb0_ready  out  1  port 0 request accepted this cycle.
- wb1_valid, wb1_addr, wb1_data, wb1_ready  same as port 0, for port 1 (load).
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_addr  in  ADDR_W  register being reserved.
- q_rs_addr, q_rt_addr, q_rd_addr  in  ADDR_W  scoreboard query addresses.
- rs_busy, rt_busy, rd_busy  out  1  the queried register has a pending write.
- rf_we  out  1  to register file WE.
- rf_waddr  out  ADDR_W  to register file write address.
- rf_wdata  out  DATA_W  to register file write data.
- err_unrsv  out  1  sticky flag: a write was accepted to a register that was not reserved.

Behaviour:
- Reset (rst asserted, any time, including mid-transfer):
  - rf_we=0, rf_waddr=0, rf_wdata=0, err_unrsv=0.
  - All busy bits cleared.
  - last_grant=1, so port 0 wins the first contention.
  - Any requests in flight are discarded.
- Arbitration (combinational):
  - Exactly one request is accepted per cycle at most.
  - One port valid: that port's ready=1.
  - Both ports valid: the port not equal to last_grant gets ready=1 (round-robin); the other port's ready=0.
  - Neither port valid: both ready=0.
  - ready depends on valid. Requesters must hold valid, addr and data stable until ready.
- Acceptance: a handshake (valid && ready) at rising edge N causes the following on that edge:
  - last_grant is set to the granted port index.
  - rf_waddr and rf_wdata are registered from the granted port.
  - rf_we=1 for cycle N+1, unless addr==0, in which case rf_we=0 and the request is silently consumed.
  - The register file writes on the falling edge inside cycle N+1. Accept-to-committed latency is therefore 1.5 cycles.
- No acceptance in a cycle: rf_we=0 next cycle. rf_waddr and rf_wdata hold their previous values.
- Scoreboard, a busy bit per register:
  - Set at the rising edge when rsv_valid=1 and rsv_addr!=0.
  - Cleared at the acceptance edge of a write to that address.
  - Same-edge reserve and clear of the same address: reserve wins, so the bit stays set.
  - Register 0 is never busy.
- Busy outputs: rs_busy, rt_busy and rd_busy are combinational reads of the current busy bits. There is no bypass of a same-cycle reserve or clear.
  - A read issued in cycle N+1 is sampled at the rising edge N+2, after the falling-edge commit, so it returns the new value.
- Single reservation rule: a register has at most one outstanding reservation. The issue stage stalls on rd_busy, so a reserve to an already-busy register is a protocol error; the bit simply stays set.
- err_unrsv: set when a write with addr!=0 is accepted while that register's busy bit is clear and no same-edge reserve targets it. It stays set until rst.

Decomposition:
- Shared package rf_pkg: ADDR_W, DATA_W, REG_ZERO constant, port index constants PORT_ALU=0 and PORT_LD=1.
- One natural sub-module: rf_scoreboard, holding the busy vector, set/clear logic, the three query muxes and the err_unrsv detection.
- The arbiter and the output register stay in the top module.

Test Plan:
- Reset behaviour: assert rst mid-stream while rf_we=1 → rf_we, rf_waddr, rf_wdata and all busy outputs go 0 immediately. After release, the first contention grants port 0.
- Single port: reserve r9, then wb0 writes r9 with 0x0000_1234 → wb0_ready=1 in the same cycle; rf_we=1 with waddr=9 and wdata=0x1234 next cycle; rs_busy(q=9) goes 1→0 at the acceptance edge; the register file reads 0x1234 at the following rising edge.
- Contention: wb0 (r10, 0xA) and wb1 (r12, 0xB) both held valid for 4 cycles → grants alternate P0, P1, P0, P1. Each write appears on rf_* exactly once, one cycle after its grant.
- Zero register: wb1 writes r0 with 0xFFFF_FFFF → wb1_ready=1; rf_we stays 0; err_unrsv stays 0; no busy bit changes.
- Reserve/clear collision: r9 busy; on the same edge wb0 writes r9 and rsv_addr=9 → rd_busy(q=9) remains 1.
- Unreserved write: wb0 writes r11, which was never reserved → err_unrsv=1 at the next rising edge and stays 1 until rst.
